mul_div_unit: RTL

//   Iterative RV64M multiply/divide unit.
//   - Executes MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU and the W variants.
//   - Radix-2, one bit per cycle, with valid/ready handshakes on both sides.
//   - Sits beside the combinational ALU in the execute stage. The core

---
 rtl/mul_div_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with a one-edge fast path for trivial divides.
module mul_div_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [OP_WIDTH-1:0]   i_op,
  input  logic [DATA_WIDTH-1:0] i_src_1,
  input  logic [DATA_WIDTH-1:0] i_src_2,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_busy
);

  localparam int DW    = DATA_WIDTH;
  localparam int WW    = WORD_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [DW-1:0] sext_w(input logic [WW-1:0] v);
    return {{(DW-WW){v[WW-1]}}, v};
  endfunction

  logic [1:0]       state;
  logic             is_w_r, is_div_r, is_rem_r, mul_hi_r, neg_r;
  logic [DW-1:0]    acc, quo, opb;
  logic [CNT_W-1:0] cnt;

  // Request decode and operand conditioning, evaluated in IDLE
  logic [3:0]    op_code;
  logic          d_is_w, d_is_div, d_is_rem, d_mul_hi, d_illegal, d_sgn1, d_sgn2;
  logic [DW-1:0] x1, x2, mag1, mag2, min_val, fast_res;
  logic          neg1, neg2, div_zero, div_ovf, d_fast;

  assign op_code = i_op[3:0];

  always_comb begin
    d_is_w    = op_code[3];
    d_is_div  = op_code[2];
    d_is_rem  = op_code[2] & op_code[1];
    d_illegal = op_code[3] & ~op_code[2] & (op_code[1:0] != 2'b00);
    d_mul_hi  = ~op_code[3] & ~op_code[2] & (op_code[1:0] != 2'b00);
    d_sgn1    = d_is_div ? ~op_code[0] : (op_code[1:0] != 2'b11);
    d_sgn2    = d_is_div ? ~op_code[0] : ~op_code[1];
    if (d_is_w) begin
      x1      = d_sgn1 ? sext_w(i_src_1[WW-1:0]) : {{(DW-WW){1'b0}}, i_src_1[WW-1:0]};
      x2      = d_sgn2 ? sext_w(i_src_2[WW-1:0]) : {{(DW-WW){1'b0}}, i_src_2[WW-1:0]};
      min_val = sext_w({1'b1, {(WW-1){1'b0}}});
    end else begin
      x1      = i_src_1;
      x2      = i_src_2;
      min_val = {1'b1, {(DW-1){1'b0}}};
    end
    neg1     = d_sgn1 & x1[DW-1];
    neg2     = d_sgn2 & x2[DW-1];
    mag1     = neg1 ? -x1 : x1;
    mag2     = neg2 ? -x2 : x2;
    div_zero = (x2 == '0);
    div_ovf  = d_sgn1 & (x1 == min_val) & (x2 == '1);
    d_fast   = d_illegal | (d_is_div & (div_zero | div_ovf));
    fast_res = '0;
    if (d_is_div && div_zero)
      fast_res = d_is_rem ? (d_is_w ? sext_w(x1[WW-1:0]) : x1) : '1;
    else if (d_is_div && div_ovf)
      fast_res = d_is_rem ? '0 : x1;
  end

  // One iteration. Multiply shifts {acc,quo} right with the multiplier in quo;
  // divide shifts the dividend out of quo's MSB into acc, quotient bits in at the LSB.
  logic [DW:0]   mul_sum, div_shift;
  logic          div_ge;
  logic [DW-1:0] n_acc, n_quo;

  always_comb begin
    mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, opb} : '0);
    div_shift = {acc, quo[DW-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    if (is_div_r) begin
      n_acc = div_ge ? (div_shift[DW-1:0] - opb) : div_shift[DW-1:0];
      n_quo = {quo[DW-2:0], div_ge};
    end else begin
      n_acc = mul_sum[DW:1];
      n_quo = {mul_sum[0], quo[DW-1:1]};
    end
  end

  // After WW multiply steps the word product sits WW bits up in {acc,quo}
  logic [2*DW-1:0] prod, prod_n;
  logic [WW-1:0]   prod_w, prod_w_n;
  logic [DW-1:0]   rv, rv_n, final_res;

  always_comb begin
    prod     = {n_acc, n_quo};
    prod_n   = neg_r ? -prod : prod;
    prod_w   = prod[DW-WW +: WW];
    prod_w_n = neg_r ? -prod_w : prod_w;
    rv       = is_rem_r ? n_acc : n_quo;
    rv_n     = neg_r ? -rv : rv;
    if (is_div_r)
      final_res = is_w_r ? sext_w(rv_n[WW-1:0]) : rv_n;
    else if (is_w_r)
      final_res = sext_w(prod_w_n);
    else
      final_res = mul_hi_r ? prod_n[2*DW-1:DW] : prod_n[DW-1:0];
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state    <= ST_IDLE;
      is_w_r   <= 1'b0;
      is_div_r <= 1'b0;
      is_rem_r <= 1'b0;
      mul_hi_r <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      quo      <= '0;
      opb      <= '0;
      cnt      <= '0;
      o_result <= '0;
    end else if (i_flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            is_w_r   <= d_is_w;
            is_div_r <= d_is_div;
            is_rem_r <= d_is_rem;
            mul_hi_r <= d_mul_hi;
            neg_r    <= d_is_rem ? neg1 : (neg1 ^ neg2);
            acc      <= '0;
            cnt      <= d_is_w ? CNT_W'(WW-1) : CNT_W'(DW-1);
            if (d_is_div) begin
              quo <= d_is_w ? {mag1[WW-1:0], {(DW-WW){1'b0}}} : mag1;
              opb <= mag2;
            end else begin
              quo <= mag2;
              opb <= mag1;
            end
            if (d_fast) begin
              o_result <= fast_res;
              state    <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc <= n_acc;
          quo <= n_quo;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            o_result <= final_res;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (state == ST_IDLE);
  assign o_valid = (state == ST_DONE);
  assign o_busy  = (state == ST_BUSY) || (state == ST_DONE);

endmodule
